// File: rtl/salsa20_pkg.sv
// Shared definitions for the Salsa20 inverse-round datapath: word/state
// widths, rotate amounts, quarter-round group tables and the FSM encoding.
package salsa20_pkg;

    localparam int WORD_W  = 32;
    localparam int STATE_W = 512;

    // Left-rotate amounts, named after the word each step updates
    localparam int ROT_B = 7;
    localparam int ROT_C = 9;
    localparam int ROT_D = 13;
    localparam int ROT_A = 18;

    typedef logic [3:0] idx_t;

    // Quarter-round groups (a,b,c,d) of the row round and the column round
    localparam idx_t ROW_IDX [4][4] = '{
        '{4'd0,  4'd1,  4'd2,  4'd3},
        '{4'd5,  4'd6,  4'd7,  4'd4},
        '{4'd10, 4'd11, 4'd8,  4'd9},
        '{4'd15, 4'd12, 4'd13, 4'd14}
    };
    localparam idx_t COL_IDX [4][4] = '{
        '{4'd0,  4'd4,  4'd8,  4'd12},
        '{4'd5,  4'd9,  4'd13, 4'd1},
        '{4'd10, 4'd14, 4'd2,  4'd6},
        '{4'd15, 4'd3,  4'd7,  4'd11}
    };

    typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_e;

    function automatic logic [WORD_W-1:0] rotl(input logic [WORD_W-1:0] x, input int n);
        return (x << n) | (x >> (WORD_W - n));
    endfunction

    // Slot (group*4 + position) that word w occupies in the row round
    function automatic int row_slot(input int w);
        int r;
        r = 0;
        for (int g = 0; g < 4; g++)
            for (int k = 0; k < 4; k++)
                if (int'(ROW_IDX[g][k]) == w) r = g * 4 + k;
        return r;
    endfunction

    // Slot (group*4 + position) that word w occupies in the column round
    function automatic int col_slot(input int w);
        int r;
        r = 0;
        for (int g = 0; g < 4; g++)
            for (int k = 0; k < 4; k++)
                if (int'(COL_IDX[g][k]) == w) r = g * 4 + k;
        return r;
    endfunction

endpackage

// File: rtl/salsa20_inv_quarter_round.sv
// Combinational inverse Salsa20 quarter round. The forward steps are undone
// in reverse order, so each step only uses words already restored.
module salsa20_inv_quarter_round
    import salsa20_pkg::*;
(
    input  logic [WORD_W-1:0] a_in,
    input  logic [WORD_W-1:0] b_in,
    input  logic [WORD_W-1:0] c_in,
    input  logic [WORD_W-1:0] d_in,
    output logic [WORD_W-1:0] a_out,
    output logic [WORD_W-1:0] b_out,
    output logic [WORD_W-1:0] c_out,
    output logic [WORD_W-1:0] d_out
);

    logic [WORD_W-1:0] a_r;
    logic [WORD_W-1:0] d_r;
    logic [WORD_W-1:0] c_r;
    logic [WORD_W-1:0] b_r;

    // Undo a, d, c, b in that order
    always_comb begin
        a_r = a_in ^ rotl(d_in + c_in, ROT_A);
        d_r = d_in ^ rotl(c_in + b_in, ROT_D);
        c_r = c_in ^ rotl(b_in + a_r, ROT_C);
        b_r = b_in ^ rotl(a_r + d_r, ROT_B);
    end

    assign a_out = a_r;
    assign b_out = b_r;
    assign c_out = c_r;
    assign d_out = d_r;

endmodule

// File: rtl/salsa20_inv_rounds.sv
// Iterative inverse of the Salsa20 double round with valid/ready handshakes.
// Default build: one inverse double round per RUN cycle.
// Define SALSA20_INV_HALF_STEP_EN for one inverse half round per cycle
// (row-undo then column-undo, alternating); results are identical.
module salsa20_inv_rounds
    import salsa20_pkg::*;
#(
    parameter int DOUBLE_ROUNDS = 10
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [STATE_W-1:0] in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [STATE_W-1:0] out_data,
    output logic               busy
);

`ifdef SALSA20_INV_HALF_STEP_EN
    localparam int STEPS = 2 * DOUBLE_ROUNDS;
`else
    localparam int STEPS = DOUBLE_ROUNDS;
`endif
    localparam int CNT_W = $clog2(STEPS + 1);

    fsm_e               fsm_q, fsm_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [STATE_W-1:0] st_q, st_d;

    logic [15:0][WORD_W-1:0] cur_w;
    logic [15:0][WORD_W-1:0] nxt_w;

    assign cur_w = st_q;

`ifdef SALSA20_INV_HALF_STEP_EN
    // Phase 0 undoes the row round, phase 1 the column round
    logic phase_q, phase_d;
    logic [15:0][WORD_W-1:0] q_in;
    logic [15:0][WORD_W-1:0] q_out;

    for (genvar g = 0; g < 4; g++) begin : g_half
        for (genvar k = 0; k < 4; k++) begin : g_sel
            assign q_in[g*4+k] = phase_q ? cur_w[COL_IDX[g][k]] : cur_w[ROW_IDX[g][k]];
        end
        salsa20_inv_quarter_round u_qr (
            .a_in (q_in[g*4+0]),  .b_in (q_in[g*4+1]),
            .c_in (q_in[g*4+2]),  .d_in (q_in[g*4+3]),
            .a_out(q_out[g*4+0]), .b_out(q_out[g*4+1]),
            .c_out(q_out[g*4+2]), .d_out(q_out[g*4+3])
        );
    end

    // Every word belongs to exactly one group per phase, so each is rewritten
    for (genvar w = 0; w < 16; w++) begin : g_wb
        localparam idx_t RS = idx_t'(row_slot(w));
        localparam idx_t CS = idx_t'(col_slot(w));
        assign nxt_w[w] = phase_q ? q_out[CS] : q_out[RS];
    end
`else
    logic [15:0][WORD_W-1:0] mid_w;

    for (genvar g = 0; g < 4; g++) begin : g_full
        salsa20_inv_quarter_round u_row (
            .a_in (cur_w[ROW_IDX[g][0]]), .b_in (cur_w[ROW_IDX[g][1]]),
            .c_in (cur_w[ROW_IDX[g][2]]), .d_in (cur_w[ROW_IDX[g][3]]),
            .a_out(mid_w[ROW_IDX[g][0]]), .b_out(mid_w[ROW_IDX[g][1]]),
            .c_out(mid_w[ROW_IDX[g][2]]), .d_out(mid_w[ROW_IDX[g][3]])
        );
        salsa20_inv_quarter_round u_col (
            .a_in (mid_w[COL_IDX[g][0]]), .b_in (mid_w[COL_IDX[g][1]]),
            .c_in (mid_w[COL_IDX[g][2]]), .d_in (mid_w[COL_IDX[g][3]]),
            .a_out(nxt_w[COL_IDX[g][0]]), .b_out(nxt_w[COL_IDX[g][1]]),
            .c_out(nxt_w[COL_IDX[g][2]]), .d_out(nxt_w[COL_IDX[g][3]])
        );
    end
`endif

    // Next-state logic: load in IDLE, iterate in RUN, hold until taken in DONE
    always_comb begin
        fsm_d = fsm_q;
        cnt_d = cnt_q;
        st_d  = st_q;
`ifdef SALSA20_INV_HALF_STEP_EN
        phase_d = phase_q;
`endif
        case (fsm_q)
            IDLE: begin
                if (in_valid) begin
                    st_d  = in_data;
                    cnt_d = '0;
                    fsm_d = RUN;
`ifdef SALSA20_INV_HALF_STEP_EN
                    phase_d = 1'b0;
`endif
                end
            end
            RUN: begin
                st_d  = nxt_w;
                cnt_d = cnt_q + CNT_W'(1);
`ifdef SALSA20_INV_HALF_STEP_EN
                phase_d = ~phase_q;
`endif
                if (cnt_q == CNT_W'(STEPS - 1)) fsm_d = DONE;
            end
            DONE: begin
                if (out_ready) fsm_d = IDLE;
            end
            default: fsm_d = IDLE;
        endcase
    end

    // State register; reset aborts any job in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q <= IDLE;
            cnt_q <= '0;
            st_q  <= '0;
`ifdef SALSA20_INV_HALF_STEP_EN
            phase_q <= 1'b0;
`endif
        end else begin
            fsm_q <= fsm_d;
            cnt_q <= cnt_d;
            st_q  <= st_d;
`ifdef SALSA20_INV_HALF_STEP_EN
            phase_q <= phase_d;
`endif
        end
    end

    // Outputs decode only the FSM state and registered data
    assign in_ready  = (fsm_q == IDLE);
    assign busy      = (fsm_q == RUN);
    assign out_valid = (fsm_q == DONE);
    assign out_data  = (fsm_q == DONE) ? st_q : '0;

endmodule
